stream_mux_nto1: RTL and testbench

STREAM_MUX_NTO1 -- requirements
Module: stream_mux_nto1

---
 rtl/stream_mux_nto1.sv | 81 ++++++++
 tb/tb_stream_mux_nto1.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream multiplexer with fixed-select or round-robin
// arbitration feeding a single output register stage.
module stream_mux_nto1 #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch
);

    logic            load_en;
    logic            gnt_vld;
    logic [SELW-1:0] gnt_idx;
    logic [SELW-1:0] ptr;
    logic            xfer;
    logic [SELW-1:0] ptr_nxt;

    assign load_en = !out_valid || out_ready;

    // Round-robin scan starts at ptr and wraps modulo N.
    always_comb begin
        int j;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        if (!mode) begin
            if (int'(sel) < N && in_valid[sel]) begin
                gnt_vld = 1'b1;
                gnt_idx = sel;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                j = int'(ptr) + i;
                if (j >= N) j = j - N;
                if (!gnt_vld && in_valid[j]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(j);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && gnt_vld) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer    = rst_n && load_en && gnt_vld;
    assign ptr_nxt = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
                out_ch    <= gnt_idx;
                if (mode) ptr <= ptr_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Scoreboard bench for stream_mux_nto1: directed stimulus pushes expected
// words, a negedge monitor pops them as the output handshakes.
module tb_stream_mux_nto1;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;

    int n_pass = 0;
    int n_total = 0;
    logic m_valid = 1'b0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    stream_mux_nto1 #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL out_word: got ch%0d %h expected none",
                         out_ch, out_data);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e[7:0]));
                chk("out_ch", 32'(out_ch), 32'(e[9:8]));
            end
        end
    end

    // One clock of stimulus; exp is the hand-computed in_ready vector.
    task automatic cyc(input logic rst, input logic md, input logic [1:0] s,
                       input logic [3:0] v, input logic [7:0] base,
                       input logic rdy, input logic [3:0] exp);
        rst_n     = rst;
        mode      = md;
        sel       = s;
        in_valid  = v;
        out_ready = rdy;
        for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = base + 8'(k);
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(exp));
        if (rst) chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (rst && exp != 4'b0) begin
            for (int k = 0; k < N; k++) begin
                if (exp[k]) sb.push_back({6'b0, 2'(k), base + 8'(k)});
            end
        end
        @(posedge clk);
        if (!rst) begin
            m_valid = 1'b0;
            sb.delete();
        end else if (exp != 4'b0) begin
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0;
        out_ready = 1'b0; in_data = '0;

        // Reset with every channel valid
        cyc(0, 1, 0, 4'b1111, 8'h10, 1, 4'b0000);
        cyc(0, 1, 0, 4'b1111, 8'h10, 1, 4'b0000);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_ch", 32'(out_ch), 32'd0);

        // Round-robin fairness, one word per cycle
        cyc(1, 1, 0, 4'b1111, 8'h20, 1, 4'b0001);
        cyc(1, 1, 0, 4'b1111, 8'h24, 1, 4'b0010);
        cyc(1, 1, 0, 4'b1111, 8'h28, 1, 4'b0100);
        cyc(1, 1, 0, 4'b1111, 8'h2C, 1, 4'b1000);
        cyc(1, 1, 0, 4'b1111, 8'h30, 1, 4'b0001);
        cyc(1, 1, 0, 4'b1111, 8'h34, 1, 4'b0010);
        cyc(1, 1, 0, 4'b1111, 8'h38, 1, 4'b0100);
        cyc(1, 1, 0, 4'b1111, 8'h3C, 1, 4'b1000);
        cyc(1, 1, 0, 4'b0000, 8'h00, 1, 4'b0000);

        // Fixed select
        cyc(1, 0, 2, 4'b1111, 8'hA0, 1, 4'b0100);
        chk("fix_out_data", 32'(out_data), 32'hA2);
        chk("fix_out_ch", 32'(out_ch), 32'd2);
        cyc(1, 0, 1, 4'b1101, 8'hB0, 1, 4'b0000);
        cyc(1, 0, 1, 4'b1101, 8'hB0, 1, 4'b0000);

        // Skip idle channels; ptr survives a fixed-mode grant
        cyc(1, 1, 0, 4'b0001, 8'h40, 1, 4'b0001);
        cyc(1, 1, 0, 4'b1001, 8'h44, 1, 4'b1000);
        cyc(1, 1, 0, 4'b1001, 8'h48, 1, 4'b0001);
        cyc(1, 0, 3, 4'b1111, 8'h4C, 1, 4'b1000);
        cyc(1, 1, 0, 4'b1111, 8'h50, 1, 4'b0010);
        cyc(1, 0, 0, 4'b0000, 8'h00, 1, 4'b0000);

        // Backpressure holds the word and blocks inputs
        cyc(1, 0, 1, 4'b1111, 8'h5B, 1, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 4'b1111, 8'h70, 0, 4'b0000);
            chk("bp_out_data", 32'(out_data), 32'h5C);
            chk("bp_out_ch", 32'(out_ch), 32'd1);
        end
        cyc(1, 0, 1, 4'b1111, 8'h60, 1, 4'b0010);
        chk("bp_reload", 32'(out_data), 32'h61);
        cyc(1, 0, 0, 4'b0000, 8'h00, 1, 4'b0000);

        // Reset mid-stream while stalled
        cyc(1, 1, 0, 4'b0100, 8'h80, 1, 4'b0100);
        cyc(1, 1, 0, 4'b0100, 8'h90, 0, 4'b0000);
        cyc(0, 1, 0, 4'b1111, 8'h90, 0, 4'b0000);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'h00);
        cyc(1, 1, 0, 4'b1010, 8'hC0, 1, 4'b0010);
        chk("post_rst_ch", 32'(out_ch), 32'd1);
        cyc(1, 1, 0, 4'b0000, 8'h00, 1, 4'b0000);
        cyc(1, 1, 0, 4'b0000, 8'h00, 1, 4'b0000);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
